// File: rtl/symbol_timing_ctrl_if.sv
// Control/status bundle between the register block and the symbol timing controller.
interface symbol_timing_ctrl_if #(
  parameter int unsigned NB_COUNT  = 2,
  parameter int unsigned NB_WINDOW = 16
);
  logic                 i_enable;
  logic [NB_COUNT-1:0]  i_phase;
  logic                 i_phase_load;
  logic                 i_start;
  logic [NB_WINDOW-1:0] i_window_len;
  logic                 o_tx_valid;
  logic                 o_rx_sample;
  logic [NB_COUNT-1:0]  o_phase;
  logic                 o_window_active;
  logic                 o_window_done;
  logic [NB_WINDOW-1:0] o_symbol_count;
  logic [1:0]           o_state;

  modport master (
    output i_enable, i_phase, i_phase_load, i_start, i_window_len,
    input  o_tx_valid, o_rx_sample, o_phase, o_window_active, o_window_done,
           o_symbol_count, o_state
  );

  modport slave (
    input  i_enable, i_phase, i_phase_load, i_start, i_window_len,
    output o_tx_valid, o_rx_sample, o_phase, o_window_active, o_window_done,
           o_symbol_count, o_state
  );
endinterface

// File: rtl/symbol_timing_ctrl.sv
// Symbol timing controller: oversampling phase counter, tx/rx strobes and a
// measurement window sequencer counting rx samples.
module symbol_timing_ctrl #(
  parameter int unsigned NB_COUNT  = 2,
  parameter int unsigned NB_WINDOW = 16
) (
  input logic                clock,
  input logic                i_reset,
  symbol_timing_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StMeasure = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [NB_COUNT-1:0]  CntMax = '1;
  localparam logic [NB_WINDOW-1:0] SymMax = '1;

  state_e               state_q, state_d;
  logic [NB_COUNT-1:0]  cnt_q, cnt_d;
  logic [NB_COUNT-1:0]  phase_q, phase_d;
  logic [NB_COUNT-1:0]  pend_q, pend_d;
  logic [NB_WINDOW-1:0] len_q, len_d;
  logic [NB_WINDOW-1:0] sym_q, sym_d;

  logic running, wrap, tx_strobe, rx_strobe;

  assign running   = (state_q != StIdle);
  assign wrap      = (cnt_q == CntMax);
  assign tx_strobe = running && wrap;
  assign rx_strobe = running && (cnt_q == phase_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + NB_COUNT'(1);
    pend_d  = bus.i_phase_load ? bus.i_phase : pend_q;
    phase_d = phase_q;
    len_d   = len_q;
    sym_d   = sym_q;

    // Changing the active phase only at the symbol boundary keeps exactly one
    // rx strobe per symbol period; in IDLE there is no period to protect.
    if (state_q == StIdle) begin
      phase_d = bus.i_phase_load ? bus.i_phase : pend_q;
    end else if (wrap) begin
      phase_d = pend_q;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.i_enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!bus.i_enable) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (bus.i_start && (bus.i_window_len != '0)) begin
          state_d = StMeasure;
          len_d   = bus.i_window_len;
          sym_d   = '0;
        end
      end
      StMeasure: begin
        if (!bus.i_enable) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (rx_strobe) begin
          sym_d = (sym_q == SymMax) ? sym_q : sym_q + NB_WINDOW'(1);
          if (sym_q == len_q - NB_WINDOW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!bus.i_enable) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      phase_q <= '0;
      pend_q  <= '0;
      len_q   <= '0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
    end
  end

  assign bus.o_tx_valid      = tx_strobe;
  assign bus.o_rx_sample     = rx_strobe;
  assign bus.o_phase         = phase_q;
  assign bus.o_window_active = (state_q == StMeasure);
  assign bus.o_window_done   = (state_q == StDone);
  assign bus.o_symbol_count  = sym_q;
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_symbol_timing_ctrl.sv
// Directed bench for symbol_timing_ctrl with NB_COUNT=2 (OS=4), NB_WINDOW=16.
module tb_symbol_timing_ctrl;

  logic clock;
  logic i_reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  symbol_timing_ctrl_if #(.NB_COUNT(2), .NB_WINDOW(16)) bus ();

  symbol_timing_ctrl #(.NB_COUNT(2), .NB_WINDOW(16)) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, tx, rx, active, done}
  logic [5:0] obs;
  assign obs = {bus.o_state, bus.o_tx_valid, bus.o_rx_sample, bus.o_window_active,
                bus.o_window_done};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    bus.i_enable = 1'b0;
    step();
  endtask

  task automatic test_reset();
    i_reset          = 1'b0;
    bus.i_enable     = 1'b0;
    bus.i_phase      = '0;
    bus.i_phase_load = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_window_len = '0;
    #2;
    n_checks++;
    if ({obs, bus.o_phase, bus.o_symbol_count} !== 24'h0)
      $display("FAIL reset_asserted: got %h want 0", {obs, bus.o_phase, bus.o_symbol_count});
    else n_pass++;
    step();
    i_reset = 1'b1;
    step();
    n_checks++;
    if ({obs, bus.o_phase, bus.o_symbol_count} !== 24'h0)
      $display("FAIL reset_released_idle: got %h want 0", {obs, bus.o_phase, bus.o_symbol_count});
    else n_pass++;
  endtask

  task automatic test_run();
    logic [5:0] exp;
    bus.i_enable = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      exp = {2'd1, (k % 4) == 0, (k % 4) == 1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL run_cycle%0d: got %b want %b", k, obs, exp);
      else n_pass++;
      step();
    end
    go_idle();
  endtask

  task automatic test_phase();
    logic [7:0] exp_rx;
    logic [1:0] exp_ph;
    exp_rx = 8'b0000_1000;
    bus.i_enable = 1'b1;
    step();                       // cnt 0
    step();                       // cnt 1
    bus.i_phase      = 2'd2;
    bus.i_phase_load = 1'b1;
    step();                       // cnt 2
    bus.i_phase_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_ph = (i < 2) ? 2'd0 : 2'd2;
      n_checks++;
      if ({bus.o_rx_sample, bus.o_phase} !== {exp_rx[7-i], exp_ph})
        $display("FAIL phase_change_i%0d: got rx=%b ph=%0d want rx=%b ph=%0d", i,
                 bus.o_rx_sample, bus.o_phase, exp_rx[7-i], exp_ph);
      else n_pass++;
      step();
    end
    step();                       // cnt 3: load on the wrap cycle
    bus.i_phase      = 2'd1;
    bus.i_phase_load = 1'b1;
    step();                       // cnt 0
    bus.i_phase_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.o_rx_sample, bus.o_phase} !== {i == 2, 2'd2})
        $display("FAIL phase_wrap_load_i%0d: got rx=%b ph=%0d want rx=%b ph=2", i,
                 bus.o_rx_sample, bus.o_phase, i == 2);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({bus.o_rx_sample, bus.o_phase} !== {1'b0, 2'd1})
      $display("FAIL phase_wrap_applied: got rx=%b ph=%0d want rx=0 ph=1",
               bus.o_rx_sample, bus.o_phase);
    else n_pass++;
    step();
    n_checks++;
    if (bus.o_rx_sample !== 1'b1)
      $display("FAIL phase_wrap_sample: got %b want 1", bus.o_rx_sample);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_window();
    logic [5:0]  exp;
    logic [15:0] exp_sym;
    bus.i_phase      = 2'd1;
    bus.i_phase_load = 1'b1;
    step();
    bus.i_phase_load = 1'b0;
    bus.i_enable     = 1'b1;
    step();                       // RUN, cnt 0
    bus.i_window_len = 16'd5;
    bus.i_start      = 1'b1;
    step();                       // MEASURE, cnt 1
    bus.i_start      = 1'b0;
    for (int j = 0; j <= 18; j++) begin
      if (j <= 16) begin
        exp     = {2'd2, (j % 4) == 2, (j % 4) == 0, 1'b1, 1'b0};
        exp_sym = 16'((j + 3) / 4);
      end else if (j == 17) begin
        exp     = {2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_sym = 16'd5;
      end else begin
        exp     = {2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_sym = 16'd5;
      end
      n_checks++;
      if ({obs, bus.o_symbol_count} !== {exp, exp_sym})
        $display("FAIL window_j%0d: got obs=%b sym=%0d want obs=%b sym=%0d", j, obs,
                 bus.o_symbol_count, exp, exp_sym);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_abort();
    // Still in RUN at cnt 0 with phase 1 from the window test.
    bus.i_window_len = 16'd10;
    bus.i_start      = 1'b1;
    step();                       // MEASURE, cnt 1
    bus.i_start      = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      n_checks++;
      if ({bus.o_state, bus.o_window_done, bus.o_symbol_count} !== {2'd2, 1'b0, 16'((j + 3) / 4)})
        $display("FAIL abort_measure_j%0d: got st=%0d done=%b sym=%0d want st=2 done=0 sym=%0d",
                 j, bus.o_state, bus.o_window_done, bus.o_symbol_count, (j + 3) / 4);
      else n_pass++;
      step();
    end
    bus.i_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({obs, bus.o_symbol_count} !== {6'b0, 16'd3})
        $display("FAIL abort_idle_k%0d: got obs=%b sym=%0d want obs=000000 sym=3", k, obs,
                 bus.o_symbol_count);
      else n_pass++;
    end
  endtask

  task automatic test_edge();
    bus.i_phase      = 2'd3;
    bus.i_phase_load = 1'b1;
    step();
    bus.i_phase_load = 1'b0;
    n_checks++;
    if (bus.o_phase !== 2'd3) $display("FAIL idle_phase_load: got %0d want 3", bus.o_phase);
    else n_pass++;
    bus.i_enable = 1'b1;
    step();
    bus.i_window_len = 16'd0;
    bus.i_start      = 1'b1;
    step();
    bus.i_start      = 1'b0;
    n_checks++;
    if ({bus.o_state, bus.o_window_active, bus.o_symbol_count} !== {2'd1, 1'b0, 16'd3})
      $display("FAIL zero_len_start: got st=%0d act=%b sym=%0d want st=1 act=0 sym=3",
               bus.o_state, bus.o_window_active, bus.o_symbol_count);
    else n_pass++;
    bus.i_window_len = 16'd4;
    bus.i_start      = 1'b1;
    bus.i_enable     = 1'b0;
    step();
    bus.i_start      = 1'b0;
    n_checks++;
    if ({bus.o_state, bus.o_window_active, bus.o_symbol_count} !== {2'd0, 1'b0, 16'd3})
      $display("FAIL disable_beats_start: got st=%0d act=%b sym=%0d want st=0 act=0 sym=3",
               bus.o_state, bus.o_window_active, bus.o_symbol_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    // Phase is 3 from the edge test.
    bus.i_enable = 1'b1;
    step();                       // RUN, cnt 0
    bus.i_window_len = 16'd5;
    bus.i_start      = 1'b1;
    step();                       // MEASURE, cnt 1
    bus.i_start      = 1'b0;
    step();
    step();                       // cnt 3
    n_checks++;
    if (obs !== {2'd2, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL pre_reset_measure: got %b want 101110", obs);
    else n_pass++;
    #3 i_reset = 1'b0;
    #1;
    n_checks++;
    if ({obs, bus.o_phase, bus.o_symbol_count} !== 24'h0)
      $display("FAIL async_reset_now: got %h want 0", {obs, bus.o_phase, bus.o_symbol_count});
    else n_pass++;
    #1 i_reset = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      exp = {2'd1, k == 4, k == 1, 1'b0, 1'b0};
      n_checks++;
      if ({obs, bus.o_symbol_count} !== {exp, 16'd0})
        $display("FAIL restart_cycle%0d: got obs=%b sym=%0d want obs=%b sym=0", k, obs,
                 bus.o_symbol_count, exp);
      else n_pass++;
      step();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_run();
    test_phase();
    test_window();
    test_abort();
    test_edge();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
